// File: rtl/quad_angle_decoder_pkg.sv
// Shared constants, types and Gray-code helpers for the quadrature angle decoder.
// Angle is kept in whole degrees; quadrature states follow the 00->10->11->01 CW order.
package quad_angle_decoder_pkg;

  localparam int DEG_PER_REV = 360;
  localparam int ANGLE_W     = 9;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b10;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ILLEGAL
  } step_e;

  function automatic logic [1:0] gray_next_cw(input logic [1:0] s);
    case (s)
      GRAY_S0: return GRAY_S1;
      GRAY_S1: return GRAY_S2;
      GRAY_S2: return GRAY_S3;
      default: return GRAY_S0;
    endcase
  endfunction

  // Both bits flipping at once cannot be attributed to a direction.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                    return STEP_NONE;
    else if (cur == ~prev)              return STEP_ILLEGAL;
    else if (cur == gray_next_cw(prev)) return STEP_CW;
    else                                return STEP_CCW;
  endfunction

endpackage

// File: rtl/quad_angle_decoder_if.sv
// Signal bundle between the encoder pins / display path and the angle decoder.
interface quad_angle_decoder_if;
  import quad_angle_decoder_pkg::*;

  // step_valid is a one-cycle strobe with no backpressure: angle and dir are
  // valid in that cycle and hold their value until the next strobe or index.
  logic               enc_a;
  logic               enc_b;
  logic               enc_z;
  logic               err_clr;
  logic [ANGLE_W-1:0] angle;
  logic               dir;
  logic               step_valid;
  logic               err_flag;

  modport master (
    output enc_a, enc_b, enc_z, err_clr,
    input  angle, dir, step_valid, err_flag
  );

  modport slave (
    input  enc_a, enc_b, enc_z, err_clr,
    output angle, dir, step_valid, err_flag
  );

endinterface

// File: rtl/quad_angle_decoder_input_filter.sv
// Two-flop synchroniser plus stability filter: a new level is accepted only after
// it has differed from the filtered output for FILT_LEN consecutive cycles.
module quad_input_filter #(
    parameter int FILT_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic [7:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_angle_decoder.sv
// Quadrature encoder front end: filtered A/B/Z, 4x decode, and a degree angle
// derived from a residual accumulator so no divider is needed.
module quad_angle_decoder
    import quad_angle_decoder_pkg::*;
#(
    parameter int CPR      = 1440,
    parameter int FILT_LEN = 16,
    parameter int INDEX_EN = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    quad_angle_decoder_if.slave enc
);

    localparam int RW = $clog2(CPR + DEG_PER_REV);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(DEG_PER_REV - 1);

    logic a_f, b_f, z_f;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .raw_i(enc.enc_a), .filt_o(a_f));
    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .raw_i(enc.enc_b), .filt_o(b_f));
    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk(clk), .rst_n(rst_n), .raw_i(enc.enc_z), .filt_o(z_f));

    logic [1:0]         ab_prev_q,    ab_prev_d;
    logic               z_prev_q,     z_prev_d;
    logic [RW-1:0]      residual_q,   residual_d;
    logic [ANGLE_W-1:0] angle_q,      angle_d;
    logic               dir_q,        dir_d;
    logic               step_valid_q, step_valid_d;
    logic               err_flag_q,   err_flag_d;

    step_e              step;
    logic               z_rise;
    logic [RW-1:0]      r_cw;
    logic signed [RW:0] r_ccw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_prev_q    <= GRAY_S0;
            z_prev_q     <= 1'b0;
            residual_q   <= '0;
            angle_q      <= '0;
            dir_q        <= DIR_CCW;
            step_valid_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            ab_prev_q    <= ab_prev_d;
            z_prev_q     <= z_prev_d;
            residual_q   <= residual_d;
            angle_q      <= angle_d;
            dir_q        <= dir_d;
            step_valid_q <= step_valid_d;
            err_flag_q   <= err_flag_d;
        end
    end

    always_comb begin
        ab_prev_d    = {a_f, b_f};
        z_prev_d     = z_f;
        step         = decode_step(ab_prev_q, {a_f, b_f});
        z_rise       = (INDEX_EN != 0) && z_f && !z_prev_q;
        r_cw         = residual_q + RW'(DEG_PER_REV);
        r_ccw        = $signed({1'b0, residual_q}) - $signed((RW + 1)'(DEG_PER_REV));
        residual_d   = residual_q;
        angle_d      = angle_q;
        dir_d        = dir_q;
        step_valid_d = 1'b0;

        if (step == STEP_ILLEGAL) begin
            err_flag_d = 1'b1;
        end else if (enc.err_clr) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q;
        end

        // Index has priority: a coincident step is dropped entirely.
        if (z_rise) begin
            residual_d = '0;
            angle_d    = '0;
        end else if (step == STEP_CW) begin
            step_valid_d = 1'b1;
            dir_d        = DIR_CW;
            if (r_cw >= RW'(CPR)) begin
                residual_d = r_cw - RW'(CPR);
                angle_d    = (angle_q == ANGLE_MAX) ? '0 : angle_q + 1'b1;
            end else begin
                residual_d = r_cw;
            end
        end else if (step == STEP_CCW) begin
            step_valid_d = 1'b1;
            dir_d        = DIR_CCW;
            // Sign bit set means the residual borrowed a full degree.
            if (r_ccw[RW]) begin
                residual_d = r_ccw[RW-1:0] + RW'(CPR);
                angle_d    = (angle_q == '0) ? ANGLE_MAX : angle_q - 1'b1;
            end else begin
                residual_d = r_ccw[RW-1:0];
            end
        end
    end

    assign enc.angle      = angle_q;
    assign enc.dir        = dir_q;
    assign enc.step_valid = step_valid_q;
    assign enc.err_flag   = err_flag_q;

endmodule

// File: tb/tb_quad_angle_decoder.sv
// Bench for quad_angle_decoder: two instances (index enabled / disabled) share one
// set of encoder pins and are compared against a position-count reference model.
module tb_quad_angle_decoder;
  import quad_angle_decoder_pkg::*;

  localparam int CPR      = 1440;
  localparam int FILT_LEN = 4;
  localparam int HOLD     = FILT_LEN + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_angle_decoder_if bus0 ();
  quad_angle_decoder_if bus1 ();

  assign bus1.enc_a   = bus0.enc_a;
  assign bus1.enc_b   = bus0.enc_b;
  assign bus1.enc_z   = bus0.enc_z;
  assign bus1.err_clr = bus0.err_clr;

  quad_angle_decoder #(.CPR(CPR), .FILT_LEN(FILT_LEN), .INDEX_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enc(bus0.slave)
  );
  quad_angle_decoder #(.CPR(CPR), .FILT_LEN(FILT_LEN), .INDEX_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enc(bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: signed count of quadrature steps since reset/index.
  logic [1:0] gray_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int  pos = 0;
  int  p0 = 0, p1 = 0;
  int  dir0 = 0, dir1 = 0;
  int  err_m = 0;
  int  exp_p0 = 0, exp_p1 = 0;
  int  pulses0 = 0, pulses1 = 0;
  logic [ANGLE_W-1:0] exp_q[$];

  function automatic int model_angle(input int p);
    longint s, q;
    s = longint'(p) * 360;
    q = s / CPR;
    if ((s % CPR) != 0 && s < 0) q = q - 1;
    return int'(((q % 360) + 360) % 360);
  endfunction

  // Scoreboard: every strobe must match the next expected angle.
  always @(negedge clk) begin
    if (bus0.step_valid === 1'b1) begin
      pulses0++;
      check_val("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("sb_angle", 32'(bus0.angle), 32'(exp_q.pop_front()));
    end
    if (bus1.step_valid === 1'b1) pulses1++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    bus0.enc_a = ab[1];
    bus0.enc_b = ab[0];
  endtask

  task automatic model_step(input int d, input bit idx);
    pos = (pos + d + 4) % 4;
    if (idx) begin
      p0 = 0;
    end else begin
      p0 += d;
      dir0 = (d > 0) ? 1 : 0;
      exp_p0++;
      exp_q.push_back(ANGLE_W'(model_angle(p0)));
    end
    p1 += d;
    dir1 = (d > 0) ? 1 : 0;
    exp_p1++;
  endtask

  task automatic step(input int d, input int hold);
    model_step(d, 1'b0);
    set_ab(gray_seq[pos]);
    wait_cycles(hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    p0 = 0; p1 = 0; dir0 = 0; dir1 = 0; err_m = 0;
  endtask

  task automatic pulse_err_clr();
    bus0.err_clr = 1'b1;
    wait_cycles(1);
    bus0.err_clr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, " angle0"}, 32'(bus0.angle), model_angle(p0));
    check_val({tag, " dir0"}, 32'(bus0.dir), dir0);
    check_val({tag, " err0"}, 32'(bus0.err_flag), err_m);
    check_val({tag, " pulses0"}, pulses0, exp_p0);
    check_val({tag, " angle1"}, 32'(bus1.angle), model_angle(p1));
    check_val({tag, " dir1"}, 32'(bus1.dir), dir1);
    check_val({tag, " err1"}, 32'(bus1.err_flag), err_m);
    check_val({tag, " pulses1"}, pulses1, exp_p1);
  endtask

  initial begin
    bus0.enc_a = 1'b0; bus0.enc_b = 1'b0; bus0.enc_z = 1'b0; bus0.err_clr = 1'b0;

    // Reset held while pins toggle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus0.enc_a = 1'($urandom_range(0, 1));
      bus0.enc_b = 1'($urandom_range(0, 1));
      bus0.enc_z = 1'($urandom_range(0, 1));
    end
    check_val("rst step_valid", 32'(bus0.step_valid), 0);
    check_state("in_reset");
    set_ab(2'b00);
    bus0.enc_z = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(HOLD + 3);
    check_state("post_reset");

    // First four CW steps: degree advances only on the fourth
    for (int i = 0; i < 4; i++) begin
      step(1, HOLD);
      check_state($sformatf("cw4_%0d", i));
    end
    for (int i = 0; i < 1436; i++) step(1, FILT_LEN + 4);
    check_state("cw_wrap");

    // One CCW from reset wraps below zero, one CW returns
    do_reset();
    wait_cycles(HOLD);
    step(-1, HOLD);
    check_state("ccw_from_0");
    step(1, HOLD);
    check_state("cw_back");

    // Glitches on A
    bus0.enc_a = 1'b1;
    wait_cycles(FILT_LEN - 1);
    bus0.enc_a = 1'b0;
    wait_cycles(HOLD);
    check_state("glitch_short");
    model_step(1, 1'b0);
    bus0.enc_a = 1'b1;
    wait_cycles(FILT_LEN);
    bus0.enc_a = 1'b0;
    wait_cycles(4);
    check_state("glitch_long");
    model_step(-1, 1'b0);
    wait_cycles(HOLD);
    check_state("glitch_return");

    // Illegal transitions and err_clr priority
    set_ab(2'b11);
    pos = 2;
    err_m = 1;
    wait_cycles(HOLD);
    check_state("illegal_00_11");
    pulse_err_clr();
    err_m = 0;
    check_state("err_clr");
    set_ab(2'b00);
    pos = 0;
    wait_cycles(6);
    pulse_err_clr();
    err_m = 1;
    check_state("err_clr_vs_set");
    wait_cycles(1);
    check_state("err_sticky");
    pulse_err_clr();
    err_m = 0;
    check_state("err_clr2");

    // Index coincident with a CW step at 137 degrees
    do_reset();
    wait_cycles(HOLD);
    for (int i = 0; i < 549; i++) step(1, FILT_LEN + 4);
    step(-1, HOLD);
    check_state("at_137");
    model_step(1, 1'b1);
    bus0.enc_z = 1'b1;
    set_ab(gray_seq[pos]);
    wait_cycles(HOLD);
    check_state("index_vs_step");
    bus0.enc_z = 1'b0;
    wait_cycles(HOLD);
    for (int i = 0; i < 4; i++) begin
      step(1, HOLD);
      check_state($sformatf("after_index_%0d", i));
    end

    // Random walk
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(FILT_LEN + 4, FILT_LEN + 8));
      check_state("walk");
    end

    // Reset while encoder rests at 11: stale prev=00 reads as illegal once
    while (pos != 2) step(1, HOLD);
    do_reset();
    err_m = 1;
    wait_cycles(HOLD);
    check_state("reset_at_11");
    pulse_err_clr();
    err_m = 0;
    check_state("reset_at_11_clr");

    check_val("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
